// File: rtl/gray_mem_arbiter.sv
// Round-robin arbiter sharing the gray image memory read port between two requesters,
// with burst ownership and a two-stage return pipeline that routes each byte back to its issuer.
module gray_mem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              busy
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..15");
    end

    localparam logic [1:0] ST_WAIT_RDY = 2'd0;
    localparam logic [1:0] ST_ARB      = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [3:0] MAX_CNT     = 4'(MAX_BURST);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_owner;
    logic [3:0]        r_burst_cnt;

    logic              w_arb_en;
    logic              w_gnt_any;
    logic              w_gnt_sel;
    logic [ADDR_W-1:0] w_gnt_addr;

    logic              r_vld_p0;
    logic              r_tag_p0;
    logic [ADDR_W-1:0] r_addr_p0;

    logic              r_rvalid0_p1;
    logic              r_rvalid1_p1;
    logic [DATA_W-1:0] r_rdata0_p1;
    logic [DATA_W-1:0] r_rdata1_p1;

    // A zero burst count means the owner's burst ended (idle gap or reset),
    // so a tie then goes to the other requester: this is what makes r0 win after reset.
    function automatic logic pick_requester(input logic       req0,
                                            input logic       req1,
                                            input logic       owner,
                                            input logic [3:0] cnt);
        logic sel;
        if (req0 && req1) begin
            if (cnt != 4'd0 && cnt < MAX_CNT) sel = owner;
            else                               sel = ~owner;
        end else begin
            sel = req1;
        end
        return sel;
    endfunction

    function automatic logic [3:0] next_burst(input logic       k,
                                              input logic       owner,
                                              input logic [3:0] cnt);
        logic [3:0] nxt;
        if (k != owner)          nxt = 4'd1;
        else if (cnt >= MAX_CNT) nxt = MAX_CNT;
        else                     nxt = cnt + 4'd1;
        return nxt;
    endfunction

    assign w_arb_en   = reset_n && (r_state == ST_ARB);
    assign w_gnt_any  = w_arb_en && (r0_req || r1_req);
    assign w_gnt_sel  = pick_requester(r0_req, r1_req, r_owner, r_burst_cnt);
    assign w_gnt_addr = w_gnt_sel ? r1_addr : r0_addr;

    assign r0_gnt = w_gnt_any && !w_gnt_sel;
    assign r1_gnt = w_gnt_any &&  w_gnt_sel;

    assign busy = r_vld_p0 | r_rvalid0_p1 | r_rvalid1_p1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_RDY: if (gray_ready) w_state_nxt = ST_ARB;
            ST_ARB:      if (!gray_ready) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (gray_ready) w_state_nxt = ST_ARB;
                else if (!busy) w_state_nxt = ST_WAIT_RDY;
            end
            default:     w_state_nxt = ST_WAIT_RDY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_WAIT_RDY;
            r_owner     <= 1'b1;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_any) begin
                r_owner     <= w_gnt_sel;
                r_burst_cnt <= next_burst(w_gnt_sel, r_owner, r_burst_cnt);
            end else if (r_state == ST_ARB) begin
                r_burst_cnt <= 4'd0;
            end
        end
    end

    // Stage A: accepted grant becomes the memory-side address and strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p0  <= 1'b0;
            r_tag_p0  <= 1'b0;
            r_addr_p0 <= '0;
        end else begin
            r_vld_p0 <= w_gnt_any;
            if (w_gnt_any) begin
                r_tag_p0  <= w_gnt_sel;
                r_addr_p0 <= w_gnt_addr;
            end
        end
    end

    // Stage B: capture memory data and steer it to the tagged requester
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0_p1 <= 1'b0;
            r_rvalid1_p1 <= 1'b0;
            r_rdata0_p1  <= '0;
            r_rdata1_p1  <= '0;
        end else begin
            r_rvalid0_p1 <= r_vld_p0 && !r_tag_p0;
            r_rvalid1_p1 <= r_vld_p0 &&  r_tag_p0;
            if (r_vld_p0 && !r_tag_p0) r_rdata0_p1 <= gray_data;
            if (r_vld_p0 &&  r_tag_p0) r_rdata1_p1 <= gray_data;
        end
    end

    assign gray_req  = r_vld_p0;
    assign gray_addr = r_addr_p0;
    assign r0_rvalid = r_rvalid0_p1;
    assign r1_rvalid = r_rvalid1_p1;
    assign r0_rdata  = r_rdata0_p1;
    assign r1_rdata  = r_rdata1_p1;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Directed bench for gray_mem_arbiter: one task per scenario, hand-derived expectations.
module tb_gray_mem_arbiter;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              gray_ready = 1'b0;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              r0_req = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic              r1_req = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic              r0_gnt, r1_gnt;
    logic              r0_rvalid, r1_rvalid;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Image memory model: odd multiplier keeps every low byte distinct
    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        return (a[7:0] * 8'd3) ^ 8'hA5;
    endfunction

    assign gray_data = pix(gray_addr);

    gray_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .gray_ready(gray_ready),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .r0_req(r0_req), .r0_addr(r0_addr), .r1_req(r1_req), .r1_addr(r1_addr),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .busy(busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the first ARB edge: cycle 0 of a scenario
    task automatic do_reset();
        reset_n = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_addr = '0;  r1_addr = '0;
        gray_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        gray_ready = 1'b1;
        r0_req = 1'b1; r1_req = 1'b1;
        r0_addr = 14'd5; r1_addr = 14'd6;
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid});
        end
        n_tests++;
        if (gray_addr !== 14'd0) begin
            n_fail++; $display("FAIL reset_addr got %0d want 0", gray_addr);
        end
        n_tests++;
        if ({r0_rdata, r1_rdata} !== 16'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0000", {r0_rdata, r1_rdata});
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_wait_gnt got %b want 00", {r0_gnt, r1_gnt});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_tie got %b want 10", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic test_single_stream();
        logic [5:0] exp_v;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            r0_req  = (c < 4);
            r0_addr = 14'(c);
            @(negedge clk);
            exp_v = {c < 4, 1'b0, (c >= 1 && c <= 4), (c >= 1 && c <= 5),
                     (c >= 2 && c <= 5), 1'b0};
            n_tests++;
            if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== exp_v) begin
                n_fail++;
                $display("FAIL stream_ctrl c=%0d got %b want %b", c,
                         {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid}, exp_v);
            end
            if (c >= 1 && c <= 4) begin
                n_tests++;
                if (gray_addr !== 14'(c - 1)) begin
                    n_fail++;
                    $display("FAIL stream_addr c=%0d got %0d want %0d", c, gray_addr, c - 1);
                end
            end
            if (c >= 2 && c <= 5) begin
                n_tests++;
                if (r0_rdata !== pix(14'(c - 2))) begin
                    n_fail++;
                    $display("FAIL stream_rdata c=%0d got %h want %h", c, r0_rdata, pix(14'(c - 2)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        int seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [ADDR_W-1:0] a0, a1;
        logic [ADDR_W-1:0] ga [14];
        logic [1:0] exp_g, exp_rv;
        do_reset();
        a0 = 14'd100; a1 = 14'd200;
        for (int c = 0; c < 14; c++) begin
            r0_req = (c < 12); r1_req = (c < 12);
            r0_addr = a0; r1_addr = a1;
            @(negedge clk);
            exp_g  = (c < 12) ? ((seq[c] == 0) ? 2'b10 : 2'b01) : 2'b00;
            exp_rv = (c >= 2) ? ((seq[c-2] == 0) ? 2'b10 : 2'b01) : 2'b00;
            n_tests++;
            if ({r0_gnt, r1_gnt} !== exp_g) begin
                n_fail++;
                $display("FAIL contend_gnt c=%0d got %b want %b", c, {r0_gnt, r1_gnt}, exp_g);
            end
            n_tests++;
            if ({r0_rvalid, r1_rvalid} !== exp_rv) begin
                n_fail++;
                $display("FAIL contend_rvalid c=%0d got %b want %b", c, {r0_rvalid, r1_rvalid}, exp_rv);
            end
            if (exp_rv == 2'b10) begin
                n_tests++;
                if (r0_rdata !== pix(ga[c-2])) begin
                    n_fail++; $display("FAIL contend_rdata0 c=%0d got %h want %h", c, r0_rdata, pix(ga[c-2]));
                end
            end else if (exp_rv == 2'b01) begin
                n_tests++;
                if (r1_rdata !== pix(ga[c-2])) begin
                    n_fail++; $display("FAIL contend_rdata1 c=%0d got %h want %h", c, r1_rdata, pix(ga[c-2]));
                end
            end
            ga[c] = '0;
            if (exp_g == 2'b10) begin ga[c] = a0; a0 = a0 + 14'd1; end
            if (exp_g == 2'b01) begin ga[c] = a1; a1 = a1 + 14'd1; end
            next_cycle();
        end
    endtask

    task automatic test_single_tie();
        do_reset();
        r0_req = 1'b1; r1_req = 1'b1;
        r0_addr = 14'd11; r1_addr = 14'd22;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL tie_first got %b want 10", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL tie_second got %b want 01", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r1_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata} !== {4'b0010, pix(14'd11)}) begin
            n_fail++;
            $display("FAIL tie_ret0 got %b/%h want 0010/%h",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, r0_rdata, pix(14'd11));
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_rvalid, r1_rvalid, r1_rdata} !== {2'b01, pix(14'd22)}) begin
            n_fail++;
            $display("FAIL tie_ret1 got %b/%h want 01/%h",
                     {r0_rvalid, r1_rvalid}, r1_rdata, pix(14'd22));
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL tie_idle got %b want 000", {r0_rvalid, r1_rvalid, busy});
        end
    endtask

    task automatic test_ready_drop();
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] ga [12];
        logic [5:0] exp_v;
        logic g1, rv1;
        do_reset();
        a = 14'd50;
        for (int c = 0; c < 12; c++) begin
            gray_ready = !(c >= 2 && c < 8);
            r1_req  = (c < 10);
            r1_addr = a;
            @(negedge clk);
            g1  = (c <= 2) || (c == 9);
            rv1 = (c >= 2 && c <= 4) || (c == 11);
            exp_v = {1'b0, g1, (c >= 1 && c <= 3) || (c == 10),
                     (c >= 1 && c <= 4) || (c >= 10), 1'b0, rv1};
            n_tests++;
            if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== exp_v) begin
                n_fail++;
                $display("FAIL drop_ctrl c=%0d got %b want %b", c,
                         {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid}, exp_v);
            end
            if (rv1) begin
                n_tests++;
                if (r1_rdata !== pix(ga[c-2])) begin
                    n_fail++; $display("FAIL drop_rdata c=%0d got %h want %h", c, r1_rdata, pix(ga[c-2]));
                end
            end
            ga[c] = a;
            if (g1) a = a + 14'd1;
            next_cycle();
        end
        gray_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        r0_req = 1'b1; r0_addr = 14'd7; r1_addr = 14'd22;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL mid_gnt0 got %b want 10", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r0_addr = 14'd8;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, gray_req, gray_addr} !== {2'b11, 14'd7}) begin
            n_fail++; $display("FAIL mid_gnt1 got %b/%0d want 11/7", {r0_gnt, gray_req}, gray_addr);
        end
        next_cycle();
        r0_req = 1'b0;
        n_tests++;
        if ({r0_rvalid, r0_rdata, gray_req} !== {1'b1, pix(14'd7), 1'b1}) begin
            n_fail++; $display("FAIL mid_pre got %b/%h want 1/%h", r0_rvalid, r0_rdata, pix(14'd7));
        end
        #1 reset_n = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 14'd9;
        #1;
        n_tests++;
        if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid, gray_addr, r0_rdata, r1_rdata}
            !== {6'b0, 14'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL mid_async got %b/%0d/%h want 000000/0/0000",
                     {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid}, gray_addr, {r0_rdata, r1_rdata});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== 6'b0) begin
            n_fail++; $display("FAIL mid_hold got %b want 000000",
                               {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid});
        end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== 6'b0) begin
            n_fail++; $display("FAIL mid_release got %b want 000000",
                               {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL mid_resume_tie got %b want 10", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL mid_resume_r1 got %b want 01", {r0_gnt, r1_gnt});
        end
        next_cycle();
        r1_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, pix(14'd9)}) begin
            n_fail++; $display("FAIL mid_ret0 got %b/%h want 10/%h",
                               {r0_rvalid, r1_rvalid}, r0_rdata, pix(14'd9));
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({r0_rvalid, r1_rvalid, r1_rdata} !== {2'b01, pix(14'd22)}) begin
            n_fail++; $display("FAIL mid_ret1 got %b/%h want 01/%h",
                               {r0_rvalid, r1_rvalid}, r1_rdata, pix(14'd22));
        end
        next_cycle();
    endtask

    task automatic test_withdrawal();
        logic [ADDR_W-1:0] a;
        logic [5:0] exp_v;
        do_reset();
        a = 14'd30;
        r1_addr = 14'd99;
        for (int c = 0; c < 9; c++) begin
            r0_req  = (c < 6);
            r0_addr = a;
            r1_req  = (c == 1);
            @(negedge clk);
            exp_v = {c < 6, 1'b0, (c >= 1 && c <= 6), (c >= 1 && c <= 7),
                     (c >= 2 && c <= 7), 1'b0};
            n_tests++;
            if ({r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid} !== exp_v) begin
                n_fail++;
                $display("FAIL withdraw_ctrl c=%0d got %b want %b", c,
                         {r0_gnt, r1_gnt, gray_req, busy, r0_rvalid, r1_rvalid}, exp_v);
            end
            if (c >= 1 && c <= 6) begin
                n_tests++;
                if (gray_addr !== 14'(29 + c)) begin
                    n_fail++; $display("FAIL withdraw_addr c=%0d got %0d want %0d", c, gray_addr, 29 + c);
                end
            end
            if (c >= 2 && c <= 7) begin
                n_tests++;
                if (r0_rdata !== pix(14'(28 + c))) begin
                    n_fail++; $display("FAIL withdraw_rdata c=%0d got %h want %h", c, r0_rdata, pix(14'(28 + c)));
                end
            end
            if (c < 6) a = a + 14'd1;
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_contention();
        test_single_tie();
        test_ready_drop();
        test_reset_midflight();
        test_withdrawal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
